// File: rtl/mmio_to_axi4_lite_bridge.sv
// Single-outstanding MMIO request to AXI4-Lite master bridge.
// A request is accepted in IDLE, then driven as one AXI4-Lite write (AW+W, B)
// or read (AR, R). The result is reported with a one-cycle response pulse.
module mmio_to_axi4_lite_bridge #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  // MMIO side
  input  logic                      mmio_request,
  input  logic                      mmio_write,
  input  logic [ADDRESS_WIDTH-1:0]  mmio_address,
  input  logic [DATA_WIDTH-1:0]     mmio_write_data,
  output logic                      mmio_ready,
  output logic                      mmio_response_valid,
  output logic [DATA_WIDTH-1:0]     mmio_read_data,
  output logic                      mmio_error,
  // AXI4-Lite write address channel
  output logic [ADDRESS_WIDTH-1:0]  M_AXI_AWADDR,
  output logic [2:0]                M_AXI_AWPROT,
  output logic                      M_AXI_AWVALID,
  input  logic                      M_AXI_AWREADY,
  // AXI4-Lite write data channel
  output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                      M_AXI_WVALID,
  input  logic                      M_AXI_WREADY,
  // AXI4-Lite write response channel
  input  logic [1:0]                M_AXI_BRESP,
  input  logic                      M_AXI_BVALID,
  output logic                      M_AXI_BREADY,
  // AXI4-Lite read address channel
  output logic [ADDRESS_WIDTH-1:0]  M_AXI_ARADDR,
  output logic [2:0]                M_AXI_ARPROT,
  output logic                      M_AXI_ARVALID,
  input  logic                      M_AXI_ARREADY,
  // AXI4-Lite read data channel
  input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                M_AXI_RRESP,
  input  logic                      M_AXI_RVALID,
  output logic                      M_AXI_RREADY
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE_ADDRESS_DATA,
    WRITE_RESPONSE,
    READ_ADDRESS,
    READ_DATA,
    RESPOND
  } state_e;

  state_e                    state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]  address_q, address_d;
  logic [DATA_WIDTH-1:0]     write_data_q, write_data_d;
  logic                      awvalid_q, awvalid_d;
  logic                      wvalid_q, wvalid_d;
  logic [DATA_WIDTH-1:0]     read_data_q, read_data_d;
  logic                      error_q, error_d;

  // Only RESP[1] (SLVERR/DECERR) is reported; RESP[0] is intentionally dropped.
  logic unused_resp_lsb;
  assign unused_resp_lsb = M_AXI_BRESP[0] ^ M_AXI_RRESP[0];

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      address_q    <= '0;
      write_data_q <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      read_data_q  <= '0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      address_q    <= address_d;
      write_data_q <= write_data_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      read_data_q  <= read_data_d;
      error_q      <= error_d;
    end
  end

  // Next-state logic: request capture, independent AW/W handshakes, response latching.
  always_comb begin
    state_d      = state_q;
    address_d    = address_q;
    write_data_d = write_data_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    read_data_d  = read_data_q;
    error_d      = error_q;
    unique case (state_q)
      IDLE: begin
        if (mmio_request) begin
          address_d = mmio_address;
          if (mmio_write) begin
            write_data_d = mmio_write_data;
            awvalid_d    = 1'b1;
            wvalid_d     = 1'b1;
            state_d      = WRITE_ADDRESS_DATA;
          end else begin
            state_d = READ_ADDRESS;
          end
        end
      end
      WRITE_ADDRESS_DATA: begin
        // AW and W retire independently; leave once neither is still pending.
        if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d)    state_d   = WRITE_RESPONSE;
      end
      WRITE_RESPONSE: begin
        if (M_AXI_BVALID) begin
          error_d     = M_AXI_BRESP[1];
          read_data_d = '0;
          state_d     = RESPOND;
        end
      end
      READ_ADDRESS: begin
        if (M_AXI_ARREADY) state_d = READ_DATA;
      end
      READ_DATA: begin
        if (M_AXI_RVALID) begin
          read_data_d = M_AXI_RDATA;
          error_d     = M_AXI_RRESP[1];
          state_d     = RESPOND;
        end
      end
      RESPOND: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All VALID/READY outputs come from registers, never from a READY input.
  assign mmio_ready          = (state_q == IDLE);
  assign mmio_response_valid = (state_q == RESPOND);
  assign mmio_read_data      = read_data_q;
  assign mmio_error          = error_q;

  assign M_AXI_AWADDR  = address_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = write_data_q;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = (state_q == WRITE_RESPONSE);
  assign M_AXI_ARADDR  = address_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = (state_q == READ_ADDRESS);
  assign M_AXI_RREADY  = (state_q == READ_DATA);

endmodule

// File: tb/tb_mmio_to_axi4_lite_bridge.sv
// Bench for mmio_to_axi4_lite_bridge: table of transactions against a
// configurable AXI4-Lite slave, with a response scoreboard and hand sequences.
module tb_mmio_to_axi4_lite_bridge;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned NV = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          mmio_request, mmio_write;
  logic [AW-1:0] mmio_address;
  logic [DW-1:0] mmio_write_data;
  logic          mmio_ready, mmio_response_valid, mmio_error;
  logic [DW-1:0] mmio_read_data;
  logic [AW-1:0] M_AXI_AWADDR, M_AXI_ARADDR;
  logic [2:0]    M_AXI_AWPROT, M_AXI_ARPROT;
  logic          M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic [DW-1:0] M_AXI_WDATA, M_AXI_RDATA;
  logic [DW/8-1:0] M_AXI_WSTRB;
  logic [1:0]    M_AXI_BRESP, M_AXI_RRESP;
  logic          M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic          M_AXI_RVALID, M_AXI_RREADY;

  mmio_to_axi4_lite_bridge #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset),
    .mmio_request(mmio_request), .mmio_write(mmio_write),
    .mmio_address(mmio_address), .mmio_write_data(mmio_write_data),
    .mmio_ready(mmio_ready), .mmio_response_valid(mmio_response_valid),
    .mmio_read_data(mmio_read_data), .mmio_error(mmio_error),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  always #5 clock = ~clock;

  // One transaction: request fields, slave behaviour, expected MMIO result.
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int unsigned aw_dly, w_dly, b_dly, ar_dly, r_dly;
    logic        early;      // slave holds every READY/resp VALID high at all times
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  vec_t        vecs [NV];
  vec_t        cur;
  exp_t        exp_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned resp_cnt = 0, acc_cnt = 0;
  int unsigned aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
  int unsigned drv_wr = 0, drv_rd = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // AXI4-Lite slave: drives at negedge, checks payload on handshakes and while stalled.
  initial begin : slave
    int unsigned awc, wc, bc, arc, rc;
    logic        p_aw, p_w, p_ar;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    awc = 0; wc = 0; bc = 0; arc = 0; rc = 0;
    p_aw = 1'b0; p_w = 1'b0; p_ar = 1'b0;
    p_awaddr = '0; p_wdata = '0; p_araddr = '0;
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_ARREADY = 1'b0;
    M_AXI_BVALID = 1'b0; M_AXI_RVALID = 1'b0;
    M_AXI_BRESP = 2'b00; M_AXI_RRESP = 2'b00; M_AXI_RDATA = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_ARREADY = 1'b0;
        M_AXI_BVALID = 1'b0; M_AXI_RVALID = 1'b0;
        awc = 0; wc = 0; bc = 0; arc = 0; rc = 0;
        p_aw = 1'b0; p_w = 1'b0; p_ar = 1'b0;
      end else begin
        if (p_aw) check("aw_hold", 64'({M_AXI_AWVALID, M_AXI_AWADDR}), 64'({1'b1, p_awaddr}));
        if (p_w)  check("w_hold",  64'({M_AXI_WVALID, M_AXI_WDATA}),   64'({1'b1, p_wdata}));
        if (p_ar) check("ar_hold", 64'({M_AXI_ARVALID, M_AXI_ARADDR}), 64'({1'b1, p_araddr}));
        M_AXI_BRESP = cur.resp; M_AXI_RRESP = cur.resp; M_AXI_RDATA = cur.rdata;
        if (M_AXI_AWVALID) begin M_AXI_AWREADY = cur.early || (awc >= cur.aw_dly); awc++; end
        else begin M_AXI_AWREADY = cur.early; awc = 0; end
        if (M_AXI_WVALID) begin M_AXI_WREADY = cur.early || (wc >= cur.w_dly); wc++; end
        else begin M_AXI_WREADY = cur.early; wc = 0; end
        if (M_AXI_ARVALID) begin M_AXI_ARREADY = cur.early || (arc >= cur.ar_dly); arc++; end
        else begin M_AXI_ARREADY = cur.early; arc = 0; end
        if (M_AXI_BREADY) begin M_AXI_BVALID = cur.early || (bc >= cur.b_dly); bc++; end
        else begin M_AXI_BVALID = cur.early; bc = 0; end
        if (M_AXI_RREADY) begin M_AXI_RVALID = cur.early || (rc >= cur.r_dly); rc++; end
        else begin M_AXI_RVALID = cur.early; rc = 0; end
        if (M_AXI_AWVALID && M_AXI_AWREADY) begin
          aw_hs++;
          check("awaddr_prot", 64'({M_AXI_AWPROT, M_AXI_AWADDR}), 64'({3'b000, cur.addr}));
        end
        if (M_AXI_WVALID && M_AXI_WREADY) begin
          w_hs++;
          check("wdata_strb", 64'({M_AXI_WSTRB, M_AXI_WDATA}), 64'({4'hF, cur.wdata}));
        end
        if (M_AXI_ARVALID && M_AXI_ARREADY) begin
          ar_hs++;
          check("araddr_prot", 64'({M_AXI_ARPROT, M_AXI_ARADDR}), 64'({3'b000, cur.addr}));
        end
        if (M_AXI_BVALID && M_AXI_BREADY) b_hs++;
        if (M_AXI_RVALID && M_AXI_RREADY) r_hs++;
        p_aw = M_AXI_AWVALID && !M_AXI_AWREADY; p_awaddr = M_AXI_AWADDR;
        p_w  = M_AXI_WVALID  && !M_AXI_WREADY;  p_wdata  = M_AXI_WDATA;
        p_ar = M_AXI_ARVALID && !M_AXI_ARREADY; p_araddr = M_AXI_ARADDR;
      end
    end
  end

  // Scoreboard push: an acceptance is certain at the next posedge.
  initial begin : accept_mon
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset && mmio_request && mmio_ready) begin
        acc_cnt++;
        e.rdata = cur.exp_rdata;
        e.err   = cur.exp_err;
        exp_q.push_back(e);
      end
    end
  end

  // Scoreboard pop: every response pulse must match the oldest expectation.
  initial begin : resp_mon
    exp_t e;
    forever begin
      @(negedge clock);
      if (mmio_response_valid) begin
        resp_cnt++;
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_resp: got pulse expected none at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("resp_rdata", 64'(mmio_read_data), 64'(e.rdata));
          check("resp_error", 64'(mmio_error), 64'(e.err));
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic wait_ready();
    int unsigned n = 0;
    while (!mmio_ready && n < 50) begin @(posedge clock); #1; n++; end
    check("ready_wait", 64'(mmio_ready), 64'(1));
  endtask

  task automatic run_vec(input vec_t v);
    int unsigned n = 0;
    int unsigned r0;
    wait_ready();
    cur = v;
    if (v.wr) drv_wr++; else drv_rd++;
    r0 = resp_cnt;
    mmio_write = v.wr; mmio_address = v.addr; mmio_write_data = v.wdata; mmio_request = 1'b1;
    @(posedge clock); #1;
    mmio_request = 1'b0;
    while (resp_cnt == r0 && n < 60) begin @(posedge clock); #1; n++; end
    check("resp_seen", 64'(resp_cnt != r0), 64'(1));
  endtask

  initial begin : main
    int unsigned n, r0, base_acc, base_ar, base_aw;
    mmio_request = 1'b0; mmio_write = 1'b0; mmio_address = '0; mmio_write_data = '0;
    cur = '{1'b0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0};
    vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1'b0, 2'b00, 32'h0,        32'h0,        1'b0};
    vecs[1] = '{1'b1, 32'h14, 32'hCAFEF00D, 3, 0, 1, 0, 0, 1'b0, 2'b10, 32'h0,        32'h0,        1'b1};
    vecs[2] = '{1'b0, 32'h20, 32'h0,        0, 0, 0, 2, 0, 1'b0, 2'b00, 32'h12345678, 32'h12345678, 1'b0};
    vecs[3] = '{1'b0, 32'h24, 32'h0,        0, 0, 0, 0, 3, 1'b0, 2'b11, 32'hA5A55A5A, 32'hA5A55A5A, 1'b1};
    vecs[4] = '{1'b1, 32'h28, 32'h01020304, 0, 2, 0, 0, 0, 1'b0, 2'b11, 32'h55555555, 32'h0,        1'b1};
    vecs[5] = '{1'b0, 32'h2C, 32'h0,        0, 0, 0, 0, 0, 1'b1, 2'b00, 32'h0BADF00D, 32'h0BADF00D, 1'b0};
    vecs[6] = '{1'b1, 32'h30, 32'h89ABCDEF, 0, 0, 0, 0, 0, 1'b1, 2'b01, 32'h77777777, 32'h0,        1'b0};
    vecs[7] = '{1'b1, 32'h34, 32'hFFFFFFFF, 1, 1, 2, 0, 0, 1'b0, 2'b01, 32'h0,        32'h0,        1'b0};

    // Reset state
    #12;
    check("rst_valids_readies", 64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY,
                                      M_AXI_RREADY, mmio_response_valid, mmio_error}), 64'(0));
    check("rst_addr_data", 64'({M_AXI_AWADDR, M_AXI_WDATA}), 64'(0));
    check("rst_araddr_rdata", 64'({M_AXI_ARADDR, mmio_read_data}), 64'(0));
    check("rst_ready", 64'(mmio_ready), 64'(1));
    @(posedge clock); #1;
    reset = 1'b0;
    check("ready_after_reset", 64'(mmio_ready), 64'(1));

    // Minimum-latency write, cycle by cycle
    cur = vecs[0];
    drv_wr++;
    mmio_write = 1'b1; mmio_address = 32'h10; mmio_write_data = 32'hDEADBEEF; mmio_request = 1'b1;
    @(posedge clock); #1;
    mmio_request = 1'b0;
    check("lat_c1_aw_w_valid", 64'({M_AXI_AWVALID, M_AXI_WVALID, mmio_ready}), 64'(3'b110));
    @(posedge clock); #1;
    check("lat_c2_bready", 64'({M_AXI_BREADY, M_AXI_AWVALID, M_AXI_WVALID}), 64'(3'b100));
    @(posedge clock); #1;
    check("lat_c3_pulse", 64'({mmio_response_valid, mmio_error}), 64'(2'b10));
    check("lat_c3_rdata", 64'(mmio_read_data), 64'(0));
    @(posedge clock); #1;
    check("lat_c4_ready", 64'({mmio_ready, mmio_response_valid}), 64'(2'b10));

    // Table of transactions
    for (int i = 0; i < int'(NV); i++) run_vec(vecs[i]);

    // Request held high through a read, then changed to a write
    wait_ready();
    base_acc = acc_cnt; base_ar = ar_hs; base_aw = aw_hs;
    cur = '{1'b0, 32'h40, 32'h0, 0, 0, 0, 1, 1, 1'b0, 2'b00, 32'hFEEDFACE, 32'hFEEDFACE, 1'b0};
    drv_rd++;
    mmio_write = 1'b0; mmio_address = 32'h40; mmio_request = 1'b1;
    n = 0;
    while (!mmio_response_valid && n < 40) begin @(posedge clock); #1; n++; end
    check("hold_first_pulse", 64'(mmio_response_valid), 64'(1));
    check("hold_single_accept", 64'(acc_cnt), 64'(base_acc + 1));
    check("hold_single_ar", 64'(ar_hs), 64'(base_ar + 1));
    cur = '{1'b1, 32'h44, 32'h0F0F0F0F, 0, 0, 0, 0, 0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0};
    drv_wr++;
    mmio_write = 1'b1; mmio_address = 32'h44; mmio_write_data = 32'h0F0F0F0F;
    @(posedge clock); #1;
    check("hold_second_ready", 64'(mmio_ready), 64'(1));
    @(posedge clock); #1;
    mmio_request = 1'b0;
    check("hold_second_accept", 64'({mmio_ready, 32'(acc_cnt)}), 64'({1'b0, 32'(base_acc + 2)}));
    r0 = resp_cnt; n = 0;
    while (resp_cnt == r0 && n < 40) begin @(posedge clock); #1; n++; end
    check("hold_second_pulse", 64'(resp_cnt != r0), 64'(1));
    check("hold_one_aw_one_ar", 64'({32'(aw_hs), 32'(ar_hs)}), 64'({32'(base_aw + 1), 32'(base_ar + 1)}));

    // Reset while waiting for the write response
    wait_ready();
    cur = '{1'b1, 32'h50, 32'h11223344, 0, 0, 5, 0, 0, 1'b0, 2'b10, 32'h0, 32'h0, 1'b1};
    drv_wr++;
    mmio_write = 1'b1; mmio_address = 32'h50; mmio_write_data = 32'h11223344; mmio_request = 1'b1;
    @(posedge clock); #1;
    mmio_request = 1'b0;
    n = 0;
    while (!M_AXI_BREADY && n < 20) begin @(posedge clock); #1; n++; end
    check("rst_mid_reach_bready", 64'(M_AXI_BREADY), 64'(1));
    @(posedge clock); #2;
    r0 = resp_cnt;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("rst_mid_async_clear", 64'({M_AXI_BREADY, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID,
                                       M_AXI_RREADY, mmio_response_valid, mmio_error}), 64'(0));
    check("rst_mid_async_addr", 64'({M_AXI_AWADDR, M_AXI_WDATA}), 64'(0));
    check("rst_mid_ready", 64'(mmio_ready), 64'(1));
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (4) begin @(posedge clock); #1; end
    check("rst_mid_no_pulse", 64'(resp_cnt), 64'(r0));
    run_vec('{1'b1, 32'h58, 32'h5A5AA5A5, 0, 0, 0, 0, 0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0});

    // One AXI transaction per accepted request; the reset write never got its B
    check("total_accepts", 64'(acc_cnt), 64'(drv_wr + drv_rd));
    check("total_aw", 64'(aw_hs), 64'(drv_wr));
    check("total_w", 64'(w_hs), 64'(drv_wr));
    check("total_b", 64'(b_hs), 64'(drv_wr - 1));
    check("total_ar", 64'(ar_hs), 64'(drv_rd));
    check("total_r", 64'(r_hs), 64'(drv_rd));
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
